// File: rtl/input_debouncer_pkg.sv
// Board-level constants shared by the debouncer and the user input device,
// so both agree on the {keys, switches} bit layout.
package input_debouncer_pkg;

  localparam int unsigned CLK_FREQ_HZ             = 50_000_000;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50_000;
  localparam int unsigned BOARD_NUM_KEYS          = 4;
  localparam int unsigned BOARD_NUM_SWITCHES      = 4;

  // Counter width for a stability window of n cycles; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/input_debouncer_debounce_bit.sv
// One input bit: 2-flop synchronizer, stability counter, stable level and a
// one-cycle pulse whenever the stable level is updated.
module debounce_bit
  import input_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic stable_o,
  output logic changed_o
);

  localparam int unsigned     CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          changed_q, changed_d;

  // Any cycle where sync2 agrees with the stable level restarts the window,
  // so bounces shorter than DEBOUNCE_CYCLES never reach the output.
  always_comb begin
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    changed_d = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      stable_d  = sync2_q;
      cnt_d     = '0;
      changed_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      stable_q  <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      changed_q <= changed_d;
    end
  end

  assign stable_o  = stable_q;
  assign changed_o = changed_q;

endmodule

// File: rtl/input_debouncer.sv
// Debounces the board pushbuttons and slide switches into clean registered
// levels plus per-bit change pulses, ordered {keys, switches}.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = BOARD_NUM_KEYS,
  parameter int unsigned NUM_SWITCHES    = BOARD_NUM_SWITCHES,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_KEYS-1:0]              raw_keys,
  input  logic [NUM_SWITCHES-1:0]          raw_switches,
  output logic [NUM_KEYS-1:0]              keys,
  output logic [NUM_SWITCHES-1:0]          switches,
  output logic [NUM_KEYS+NUM_SWITCHES-1:0] changed
);

  localparam int unsigned NB = NUM_KEYS + NUM_SWITCHES;

  logic [NUM_KEYS-1:0] keys_pol;
  logic [NB-1:0]       raw_all;
  logic [NB-1:0]       stable_all;
  logic [NB-1:0]       changed_all;

  // Inverting ahead of the synchronizer makes a released key read 0 straight
  // out of reset, so no spurious event appears at power-up.
  assign keys_pol = raw_keys ^ {NUM_KEYS{KEY_ACTIVE_LOW}};
  assign raw_all  = {keys_pol, raw_switches};

  for (genvar i = 0; i < NB; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .raw_i    (raw_all[i]),
      .stable_o (stable_all[i]),
      .changed_o(changed_all[i])
    );
  end

  assign keys     = stable_all[NUM_SWITCHES +: NUM_KEYS];
  assign switches = stable_all[NUM_SWITCHES-1:0];
  assign changed  = changed_all;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: a DEBOUNCE_CYCLES=4 instance for the
// main scenarios and a DEBOUNCE_CYCLES=1 instance for the minimum window.
module tb_input_debouncer;

  logic       clk;
  logic       reset_n;
  logic [3:0] raw_keys;
  logic [3:0] raw_switches;
  logic [3:0] keys, switches;
  logic [7:0] changed;
  logic [3:0] keys1, switches1;
  logic [7:0] changed1;

  int pass_cnt;
  int total_cnt;

  input_debouncer #(
    .NUM_KEYS(4), .NUM_SWITCHES(4), .DEBOUNCE_CYCLES(4), .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .raw_keys(raw_keys), .raw_switches(raw_switches),
    .keys(keys), .switches(switches), .changed(changed)
  );

  input_debouncer #(
    .NUM_KEYS(4), .NUM_SWITCHES(4), .DEBOUNCE_CYCLES(1), .KEY_ACTIVE_LOW(1'b1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .raw_keys(raw_keys), .raw_switches(raw_switches),
    .keys(keys1), .switches(switches1), .changed(changed1)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- drivers ----------------
  // Advance one rising edge and settle; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Return to a known idle state: keys released (high), switches low.
  task automatic do_reset();
    reset_n      = 1'b0;
    raw_keys     = 4'hF;
    raw_switches = 4'h0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n      = 1'b0;
    raw_keys     = 4'hF;
    raw_switches = 4'h0;
    for (int k = 1; k <= 23; k++) begin
      if (k == 4) reset_n = 1'b1;
      tick();
      total_cnt++;
      if ({keys, switches, changed} !== 16'h0000) begin
        $display("FAIL reset_idle cycle %0d: got keys=%h sw=%h chg=%h want all 0", k, keys, switches, changed);
      end else pass_cnt++;
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] ek;
    logic [7:0] ec;
    do_reset();
    raw_keys = 4'hE;
    for (int k = 1; k <= 10; k++) begin
      tick();
      ek = (k >= 6) ? 4'h1 : 4'h0;
      ec = (k == 6) ? 8'h10 : 8'h00;
      total_cnt++;
      if (keys !== ek || switches !== 4'h0 || changed !== ec) begin
        $display("FAIL clean_press edge %0d: got keys=%h sw=%h chg=%h want keys=%h sw=0 chg=%h", k, keys, switches, changed, ek, ec);
      end else pass_cnt++;
      ek = (k >= 3) ? 4'h1 : 4'h0;
      ec = (k == 3) ? 8'h10 : 8'h00;
      total_cnt++;
      if (keys1 !== ek || changed1 !== ec) begin
        $display("FAIL min_window_press edge %0d: got keys=%h chg=%h want keys=%h chg=%h", k, keys1, changed1, ek, ec);
      end else pass_cnt++;
    end
    raw_keys = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      tick();
      ek = (k >= 6) ? 4'h0 : 4'h1;
      ec = (k == 6) ? 8'h10 : 8'h00;
      total_cnt++;
      if (keys !== ek || changed !== ec) begin
        $display("FAIL clean_release edge %0d: got keys=%h chg=%h want keys=%h chg=%h", k, keys, changed, ek, ec);
      end else pass_cnt++;
    end
  endtask

  task automatic test_bounce();
    logic [3:0] es;
    logic [7:0] ec;
    logic [9:0] pattern;
    int         pulses;
    pattern = 10'b1100110011; // bit k-1 drives before edge k, then held high
    pulses  = 0;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      raw_switches[2] = (k <= 10) ? pattern[k-1] : 1'b1;
      tick();
      es = (k >= 14) ? 4'h4 : 4'h0;
      ec = (k == 14) ? 8'h04 : 8'h00;
      if (changed[2] === 1'b1) pulses++;
      total_cnt++;
      if (switches !== es || changed !== ec || keys !== 4'h0) begin
        $display("FAIL bounce edge %0d: got sw=%h chg=%h keys=%h want sw=%h chg=%h keys=0", k, switches, changed, keys, es, ec);
      end else pass_cnt++;
    end
    total_cnt++;
    if (pulses !== 1) begin
      $display("FAIL bounce_pulse_count: got %0d want 1", pulses);
    end else pass_cnt++;
  endtask

  task automatic test_short_glitch();
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      raw_switches[1] = (k <= 3) ? 1'b1 : 1'b0;
      tick();
      total_cnt++;
      if (switches !== 4'h0 || changed !== 8'h00) begin
        $display("FAIL short_glitch edge %0d: got sw=%h chg=%h want sw=0 chg=00", k, switches, changed);
      end else pass_cnt++;
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] es;
    logic [7:0] ec;
    do_reset();
    raw_switches = 4'hA;
    for (int k = 1; k <= 9; k++) begin
      tick();
      es = (k >= 6) ? 4'hA : 4'h0;
      ec = (k == 6) ? 8'h0A : 8'h00;
      total_cnt++;
      if (switches !== es || changed !== ec) begin
        $display("FAIL simultaneous edge %0d: got sw=%h chg=%h want sw=%h chg=%h", k, switches, changed, es, ec);
      end else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_count();
    logic [3:0] es;
    logic [7:0] ec;
    do_reset();
    raw_switches = 4'h1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      total_cnt++;
      if (switches !== 4'h0 || changed !== 8'h00) begin
        $display("FAIL mid_count_pre edge %0d: got sw=%h chg=%h want sw=0 chg=00", k, switches, changed);
      end else pass_cnt++;
    end
    reset_n = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      total_cnt++;
      if (switches !== 4'h0 || changed !== 8'h00) begin
        $display("FAIL mid_count_in_reset cycle %0d: got sw=%h chg=%h want sw=0 chg=00", k, switches, changed);
      end else pass_cnt++;
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      es = (k >= 6) ? 4'h1 : 4'h0;
      ec = (k == 6) ? 8'h01 : 8'h00;
      total_cnt++;
      if (switches !== es || changed !== ec) begin
        $display("FAIL mid_count_after edge %0d: got sw=%h chg=%h want sw=%h chg=%h", k, switches, changed, es, ec);
      end else pass_cnt++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    pass_cnt     = 0;
    total_cnt    = 0;
    reset_n      = 1'b0;
    raw_keys     = 4'hF;
    raw_switches = 4'h0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_short_glitch();
    test_simultaneous();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
